// File: rtl/dcache_pkg.sv
// dcache_pkg: shared FSM state type, address-split helpers and byte-lane mask for data_cache
package dcache_pkg;
  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;
  function automatic int word_bits(input int line_words);
    return $clog2(line_words);
  endfunction
  function automatic int set_bits(input int num_sets);
    return $clog2(num_sets);
  endfunction
  function automatic int tag_bits(input int line_words, input int num_sets);
    return 30 - $clog2(line_words) - $clog2(num_sets);
  endfunction
  function automatic logic [3:0] lane_mask(input logic sb, input logic [1:0] off);
    return sb ? 4'b0001 << off : 4'hF;
  endfunction
endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: pipeline-side and backing-memory-side signals of data_cache
// slave  = the cache: takes the access and memReadData/memReady, drives data/stall and the memory request
// master = the pipeline plus backing memory, opposite directions
interface data_cache_if;
  logic [31:0] dataAddress;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic        sb;
  logic [31:0] data;
  logic        stall;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [31:0] memReadData;
  logic        memReady;
  modport slave (
    input  dataAddress, writeData, memRead, memWrite, sb, memReadData, memReady,
    output data, stall, memReq, memWe, memAddress, memWriteData
  );
  modport master (
    output dataAddress, writeData, memRead, memWrite, sb, memReadData, memReady,
    input  data, stall, memReq, memWe, memAddress, memWriteData
  );
endinterface

// File: rtl/dcache_data_array.sv
// dcache_data_array: NUM_SETS x LINE_WORDS x 32 line storage, combinational read, byte-enabled write
// clk_i clock; set_i line index shared by both ports; rword_i/rdata_o read port;
// we_i/be_i/wword_i/wdata_i write port
module dcache_data_array #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                          clk_i,
  input  logic [$clog2(NUM_SETS)-1:0]   set_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rword_i,
  output logic [31:0]                   rdata_o,
  input  logic                          we_i,
  input  logic [3:0]                    be_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wword_i,
  input  logic [31:0]                   wdata_i
);
  logic [31:0] mem_q [NUM_SETS*LINE_WORDS];
  assign rdata_o = mem_q[{set_i, rword_i}];
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++)
      if (we_i && be_i[b]) mem_q[{set_i, wword_i}][8*b +: 8] <= wdata_i[8*b +: 8];
  end
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back write-allocate data cache with word-serial backing memory
// clock/reset: sole clock, synchronous active-high reset
// bus (data_cache_if.slave): pipeline access in, data/stall out, word-serial backing-memory request
// DCACHE_PERF_CNT_EN: when defined, adds saturating hitCount/missCount outputs
module data_cache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic clock,
  input  logic reset,
`ifdef DCACHE_PERF_CNT_EN
  output logic [31:0] hitCount,
  output logic [31:0] missCount,
`endif
  data_cache_if.slave bus
);
  localparam int WB = word_bits(LINE_WORDS);
  localparam int SB = set_bits(NUM_SETS);
  localparam int TB = tag_bits(LINE_WORDS, NUM_SETS);
  localparam logic [WB-1:0] K_LAST = WB'(LINE_WORDS - 1);
  state_e state_q, state_d;
  logic [WB-1:0] k_q, k_d;
  logic [NUM_SETS-1:0] valid_q, dirty_q;
  logic [TB-1:0] tag_q [NUM_SETS];
  logic [WB-1:0] word, rword, wword;
  logic [SB-1:0] set;
  logic [TB-1:0] tag;
  logic [31:0] rdata, wdata, data, mem_addr, mem_wdata;
  logic [3:0] be;
  logic req, store, hit, last, rdy, we, stall, mem_req, mem_we;
  assign word  = bus.dataAddress[2 +: WB];
  assign set   = bus.dataAddress[2+WB +: SB];
  assign tag   = bus.dataAddress[31 -: TB];
  assign store = bus.memWrite;
  assign req   = bus.memRead | bus.memWrite;
  assign hit   = valid_q[set] && tag_q[set] == tag;
  assign last  = k_q == K_LAST;
  assign rdy   = bus.memReady;
  // the victim is streamed out of the same set, so writeback borrows the read port at word k
  assign rword = state_q == WRITEBACK ? k_q : word;
  dcache_data_array #(.NUM_SETS(NUM_SETS), .LINE_WORDS(LINE_WORDS)) u_data (
    .clk_i   (clock),
    .set_i   (set),
    .rword_i (rword),
    .rdata_o (rdata),
    .we_i    (we),
    .be_i    (be),
    .wword_i (wword),
    .wdata_i (wdata)
  );
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    stall     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    data      = '0;
    we        = 1'b0;
    be        = lane_mask(bus.sb, bus.dataAddress[1:0]);
    wword     = word;
    wdata     = bus.sb ? {4{bus.writeData[7:0]}} : bus.writeData;
    unique case (state_q)
      IDLE: begin
        we      = req && hit && store;
        data    = req && hit && !store ? rdata : '0;
        stall   = req && !hit;
        state_d = !(req && !hit) ? IDLE : dirty_q[set] ? WRITEBACK : REFILL;
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {tag_q[set], set, k_q, 2'b00};
        mem_wdata = rdata;
        k_d       = rdy ? k_q + 1'b1 : k_q;
        state_d   = rdy && last ? REFILL : WRITEBACK;
      end
      REFILL: begin
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {tag, set, k_q, 2'b00};
        we       = rdy;
        be       = 4'hF;
        wword    = k_q;
        wdata    = bus.memReadData;
        k_d      = rdy ? k_q + 1'b1 : k_q;
        state_d  = rdy && last ? IDLE : REFILL;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      if (state_q == IDLE && req && hit && store) dirty_q[set] <= 1'b1;
      if (state_q == WRITEBACK && rdy && last) dirty_q[set] <= 1'b0;
      if (state_q == REFILL && rdy && last) begin
        valid_q[set] <= 1'b1;
        dirty_q[set] <= 1'b0;
        tag_q[set]   <= tag;
      end
    end
  end
  assign bus.data         = data;
  assign bus.stall        = stall;
  assign bus.memReq       = mem_req;
  assign bus.memWe        = mem_we;
  assign bus.memAddress   = mem_addr;
  assign bus.memWriteData = mem_wdata;
`ifdef DCACHE_PERF_CNT_EN
  // replay_q marks the first IDLE cycle after a refill, whose hit is the held miss, not a new hit
  logic replay_q;
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic hit_ev, miss_ev;
  assign hit_ev  = state_q == IDLE && req && hit && !replay_q;
  assign miss_ev = state_q == IDLE && req && !hit;
  always_ff @(posedge clock) begin
    if (reset) begin
      replay_q   <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      replay_q   <= state_q == REFILL && rdy && last ? 1'b1 : state_q == IDLE ? 1'b0 : replay_q;
      hit_cnt_q  <= hit_cnt_q + 32'(hit_ev && !(&hit_cnt_q));
      miss_cnt_q <= miss_cnt_q + 32'(miss_ev && !(&miss_cnt_q));
    end
  end
  assign hitCount  = hit_cnt_q;
  assign missCount = miss_cnt_q;
`endif
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: directed self-checking bench for data_cache with a word-serial memory model
module tb_data_cache;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  data_cache_if bus();
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] hc, mc;
`endif
  data_cache dut (
    .clock     (clk),
    .reset     (rst),
`ifdef DCACHE_PERF_CNT_EN
    .hitCount  (hc),
    .missCount (mc),
`endif
    .bus       (bus)
  );
  logic [31:0] bmem [0:1023];
  logic pulse_mode = 1'b0;
  logic [1:0] gap = 2'd0;
  assign bus.memReadData = bmem[bus.memAddress[11:2]];
  assign bus.memReady = pulse_mode ? (bus.memReq && gap == 2'd2) : 1'b1;
  always @(posedge clk) gap <= (!bus.memReq || bus.memReady) ? 2'd0 : gap + 2'd1;
  int checks = 0, fails = 0, viol = 0, cyc;
  logic [31:0] rd;
  logic [31:0] la[$], ld[$];
  logic lw[$];
  logic [31:0] wb_exp [4];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic access(input logic [31:0] a, input logic r, input logic w, input logic s,
                        input logic [31:0] wd, output int n, output logic [31:0] rdata);
    logic [31:0] pa;
    logic pend;
    la.delete(); ld.delete(); lw.delete();
    pend = 1'b0;
    pa = '0;
    bus.dataAddress = a; bus.memRead = r; bus.memWrite = w; bus.sb = s; bus.writeData = wd;
    n = 0;
    @(negedge clk);
    while (bus.stall && n < 100) begin
      n++;
      if (pend && bus.memAddress != pa) viol++;
      if (bus.memReq && bus.memReady) begin
        la.push_back(bus.memAddress);
        ld.push_back(bus.memWriteData);
        lw.push_back(bus.memWe);
        if (bus.memWe) bmem[bus.memAddress[11:2]] = bus.memWriteData;
      end
      pend = bus.memReq && !bus.memReady;
      pa = bus.memAddress;
      @(negedge clk);
    end
    rdata = bus.data;
    @(posedge clk);
    #1;
    bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.sb = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < 1024; i++) bmem[i] = '0;
    bmem[32'h10] = 32'h11; bmem[32'h11] = 32'h22; bmem[32'h12] = 32'h33; bmem[32'h13] = 32'h44;
    bmem[32'h50] = 32'h55; bmem[32'h51] = 32'h66; bmem[32'h52] = 32'h77; bmem[32'h53] = 32'h88;
    bmem[32'h20] = 32'hA0; bmem[32'h21] = 32'hA1; bmem[32'h22] = 32'hA2; bmem[32'h23] = 32'hA3;
    bus.dataAddress = '0; bus.writeData = '0; bus.memRead = 1'b0; bus.memWrite = 1'b0; bus.sb = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("rst_memReq", {31'b0, bus.memReq}, 32'd0);
    chk("rst_memWe", {31'b0, bus.memWe}, 32'd0);
    chk("rst_memAddress", bus.memAddress, 32'd0);
    chk("rst_memWriteData", bus.memWriteData, 32'd0);
    chk("rst_data", bus.data, 32'd0);
    @(posedge clk);
    #1;
    access(32'h40, 1'b1, 1'b0, 1'b0, 32'h0, cyc, rd);
    chk("t1_stall_cycles", cyc, 32'd5);
    chk("t1_data", rd, 32'h11);
    chk("t1_nreq", la.size(), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", la[i], 32'h40 + 32'(4 * i));
      chk("t1_we", {31'b0, lw[i]}, 32'd0);
    end
`ifdef DCACHE_PERF_CNT_EN
    chk("t1_missCount", mc, 32'd1);
    chk("t1_hitCount", hc, 32'd0);
`endif
    access(32'h44, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF, cyc, rd);
    chk("t2_st_stall", cyc, 32'd0);
    chk("t2_st_nreq", la.size(), 32'd0);
    access(32'h44, 1'b1, 1'b0, 1'b0, 32'h0, cyc, rd);
    chk("t2_ld_stall", cyc, 32'd0);
    chk("t2_ld_data", rd, 32'hDEADBEEF);
    access(32'h45, 1'b0, 1'b1, 1'b1, 32'hAAAAAA12, cyc, rd);
    chk("t3_sb_stall", cyc, 32'd0);
    access(32'h44, 1'b1, 1'b0, 1'b0, 32'h0, cyc, rd);
    chk("t3_ld_data", rd, 32'hDEAD12EF);
    access(32'h40, 1'b1, 1'b0, 1'b0, 32'h0, cyc, rd);
    chk("t3_neighbour", rd, 32'h11);
    wb_exp[0] = 32'h11; wb_exp[1] = 32'hDEAD12EF; wb_exp[2] = 32'h33; wb_exp[3] = 32'h44;
    access(32'h140, 1'b1, 1'b0, 1'b0, 32'h0, cyc, rd);
    chk("t4_stall_cycles", cyc, 32'd9);
    chk("t4_data", rd, 32'h55);
    chk("t4_nreq", la.size(), 32'd8);
    for (int i = 0; i < 4; i++) begin
      chk("t4_wb_addr", la[i], 32'h40 + 32'(4 * i));
      chk("t4_wb_we", {31'b0, lw[i]}, 32'd1);
      chk("t4_wb_data", ld[i], wb_exp[i]);
      chk("t4_rf_addr", la[i+4], 32'h140 + 32'(4 * i));
      chk("t4_rf_we", {31'b0, lw[i+4]}, 32'd0);
    end
    pulse_mode = 1'b1;
    viol = 0;
    access(32'h84, 1'b1, 1'b0, 1'b0, 32'h0, cyc, rd);
    chk("t5_stall_cycles", cyc, 32'd13);
    chk("t5_data", rd, 32'hA1);
    chk("t5_addr_stable", viol, 32'd0);
    chk("t5_nreq", la.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t5_addr", la[i], 32'h80 + 32'(4 * i));
    pulse_mode = 1'b0;
    bus.dataAddress = 32'h240; bus.memRead = 1'b1;
    @(negedge clk);
    chk("t6_miss_stall", {31'b0, bus.stall}, 32'd1);
    @(negedge clk);
    chk("t6_word0_addr", bus.memAddress, 32'h240);
    @(negedge clk);
    chk("t6_word1_addr", bus.memAddress, 32'h244);
    rst = 1'b1;
    bus.memRead = 1'b0;
    @(negedge clk);
    chk("t6_rst_memReq", {31'b0, bus.memReq}, 32'd0);
    chk("t6_rst_stall", {31'b0, bus.stall}, 32'd0);
    chk("t6_rst_memAddress", bus.memAddress, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    access(32'h40, 1'b1, 1'b0, 1'b0, 32'h0, cyc, rd);
    chk("t6_remiss_cycles", cyc, 32'd5);
    chk("t6_remiss_data", rd, 32'h11);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/data_cache.md
# data_cache

Parametrised direct-mapped, write-back, write-allocate data cache. It sits in the MEM stage between the EX_MEM buffer and a word-serial backing memory. A hit completes in the same cycle with no stall, exactly like the flat data memory. A miss asserts `stall`, writes back a dirty victim, refills the line, and then completes the access.

## Interface
Parameters:
- `NUM_SETS`, default 16: number of lines; power of 2, ≥2.
- `LINE_WORDS`, default 4: 32-bit words per line; power of 2, ≥2.

Ports (clock and reset use the codebase names; reset is synchronous and active-high, one clock):
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `dataAddress`  in  32  byte address from EX_MEM ALU result.
- `writeData`  in  32  store data.
- `memRead`  in  1  load request.
- `memWrite`  in  1  store request.
- `sb`  in  1  with `memWrite`: byte store of `writeData[7:0]`.
- `data`  out  32  load data; valid when `memRead` and `stall`=0.
- `stall`  out  1  pipeline must hold PC, IF_ID, ID_EX and EX_MEM while high.
- `memReq`  out  1  backing-memory word request.
- `memWe`  out  1  1 = write (writeback), 0 = read (refill).
- `memAddress`  out  32  word-aligned backing address.
- `memWriteData`  out  32  writeback word.
- `memReadData`  in  32  refill word; sampled when `memReady`.
- `memReady`  in  1  word accepted or returned this cycle.

## Operation
- Address split:
  - offset = `[1:0]`
  - word = next log2(LINE_WORDS) bits
  - set = next log2(NUM_SETS) bits
  - tag = remaining upper bits
- Per line state: valid bit, dirty bit, tag, and LINE_WORDS data words.
- FSM states: IDLE, WRITEBACK, REFILL.
- IDLE behaviour:
  - hit = valid && tag match.
  - Read hit: `data` = addressed word, combinationally.
  - Store hit: at the edge, write the word, or only byte lane `dataAddress[1:0]` when `sb`; set dirty. `stall`=0.
  - Miss on a dirty victim: `stall`=1 combinationally; go to WRITEBACK.
  - Miss otherwise: `stall`=1 combinationally; go to REFILL.
- WRITEBACK:
  - Drive `memReq`=1, `memWe`=1, `memAddress`={victim tag, set, k, 2'b00}, `memWriteData`=word k, for k = 0..LINE_WORDS-1.
  - Advance k on each edge with `memReady`=1.
  - After the last word: clear dirty and go to REFILL.
- REFILL:
  - Drive `memReq`=1, `memWe`=0, `memAddress`={new tag, set, k, 2'b00}.
  - On each `memReady` edge, store `memReadData` into word k.
  - After the last word: set valid, tag, dirty=0; return to IDLE.
- The held access replays in IDLE. It now hits, so `stall` drops and a store merges into the line (write-allocate).
- `memRead` and `memWrite` both high: treat as a store.
- Neither high: `stall`=0, no state change.
- `data` = 0 when there is no read hit.

## Timing
- Reset values:
  - FSM = IDLE
  - all valid and dirty bits = 0
  - `memReq` = `memWe` = 0
  - `memAddress` = `memWriteData` = 0
  - counters = 0
  - `stall` = 0 absent a request
- Hit latency: 0 cycles (combinational read; store commits at the edge).
- Miss stall with `memReady` tied high:
  - clean victim: 1 + LINE_WORDS cycles
  - dirty victim: 1 + 2·LINE_WORDS cycles
  - each cycle without `memReady` adds one.
- Handshake:
  - While `memReq`=1, `memAddress`, `memWe` and `memWriteData` stay stable until an edge with `memReady`=1.
  - `memReq` may stay high back-to-back across words.
  - `memReq` is 0 in IDLE.
- `memReady` while `memReq`=0 is ignored.
- Reset mid-operation: at the next edge, go to IDLE, clear all valid and dirty bits, `memReq`=0. Any dirty data in flight is discarded.
- Word index wraps: k counts 0..LINE_WORDS-1 and then clears.

## Configuration
- `DCACHE_PERF_CNT_EN` defined: adds outputs `hitCount` and `missCount` (32-bit each).
  - `hitCount` increments on each IDLE-state access with `stall`=0 that did not come from a replay after a miss.
  - `missCount` increments once per miss detection.
  - Both saturate at 0xFFFFFFFF.
- Undefined: those ports and registers are absent; the rest of the behaviour is identical.

## Structure
- Package `dcache_pkg` holds:
  - the FSM state enum (IDLE, WRITEBACK, REFILL)
  - functions deriving WORD_BITS, SET_BITS and TAG_BITS from the parameters
  - the byte-lane mask helper for `sb`
- One sub-module, `dcache_data_array`:
  - NUM_SETS × LINE_WORDS × 32 storage
  - combinational read port
  - single write port with a 4-bit byte-enable
- Tag, valid and dirty storage and the FSM stay in `data_cache`.

## Test plan
Defaults (16 sets, 4 words per line):
- Load 0x40 into an empty cache, `memReady`=1, memory returns 0x11, 0x22, 0x33, 0x44 → `memReq` reads 0x40, 0x44, 0x48, 0x4C; `stall` high 5 cycles; `data`=0x11; `missCount`=1.
- Store word 0xDEADBEEF to 0x44, then load 0x44 → `stall`=0 throughout, no `memReq`, `data`=0xDEADBEEF.
- `sb` 0x12 to 0x45, then load 0x44 → `data`=0xDEAD12EF.
- Load 0x140 (same set 4, different tag) → writeback to 0x40..0x4C with `memWe`=1 and word 0x44 = 0xDEAD12EF, then refill from 0x140..0x14C; `stall` high 9 cycles.
- `memReady` pulsed every 3rd cycle during a refill → `memAddress` stable between pulses; `stall` high 1 + 12 cycles.
- Assert `reset` during the second refill word → `memReq`=0 next cycle; a subsequent load of 0x40 misses again.
